// File: rtl/demux4_pkg.sv
// Shared definitions for the 1-to-4 demultiplexer/router.
package demux4_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] chan_t;

    // Round-robin successor of a channel index; 3 wraps back to 0.
    function automatic chan_t next_slot(input chan_t cur);
        return cur + chan_t'(1'b1);
    endfunction

endpackage

// File: rtl/demux_chan_buf.sv
// One-entry valid/ready holding register for a single output channel.
// A load and a drain in the same cycle replace the word without a bubble.
module demux_chan_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] load_data,
    output logic         full,
    output logic [W-1:0] data
);

    logic         full_r;
    logic [W-1:0] data_r;

    // Occupancy flag and held word; the word keeps its value after a drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 1'b0;
            data_r <= {W{1'b0}};
        end else begin
            if (load) begin
                full_r <= 1'b1;
                data_r <= load_data;
            end else if (drain) begin
                full_r <= 1'b0;
                data_r <= data_r;
            end else begin
                full_r <= full_r;
                data_r <= data_r;
            end
        end
    end

    assign full = full_r;
    assign data = data_r;

endmodule

// File: rtl/demux4_router.sv
// Registered 1-to-4 router: steers each accepted word into the holding
// buffer of the addressed channel, either by explicit select or by a
// round-robin slot counter (TDM mode) with start-of-frame realignment.
module demux4_router
    import demux4_pkg::*;
#(
    parameter int W           = 8,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_sof,
    output logic [NCH-1:0]     out_valid,
    input  logic [NCH-1:0]     out_ready,
    output logic [NCH*W-1:0]   out_data,
    output logic [SEL_W-1:0]   slot,
    output logic               resync
);

    chan_t          dest_s;
    logic           acc_s;
    logic [NCH-1:0] full_s;
    logic [NCH-1:0] load_s;
    logic [NCH-1:0] drain_s;
    chan_t          slot_r;
    logic           resync_r;

    // Destination: explicit select, or slot counter forced to 0 on start of frame.
    always_comb begin
        dest_s = in_sel;
        if (ROUND_ROBIN) begin
            if (in_sof) begin
                dest_s = {SEL_W{1'b0}};
            end else begin
                dest_s = slot_r;
            end
        end else begin
            dest_s = in_sel;
        end
    end

    // Ready only depends on the addressed channel, so stalls stay isolated.
    always_comb begin
        in_ready = !full_s[dest_s] || out_ready[dest_s];
        acc_s    = in_valid && in_ready;
    end

    genvar k;
    generate
        for (k = 0; k < NCH; k++) begin : g_chan
            assign load_s[k]  = acc_s && (dest_s == chan_t'(k));
            assign drain_s[k] = full_s[k] && out_ready[k];

            demux_chan_buf #(.W(W)) u_buf (
                .clk       (clk),
                .rst       (rst),
                .load      (load_s[k]),
                .drain     (drain_s[k]),
                .load_data (in_data),
                .full      (full_s[k]),
                .data      (out_data[k*W +: W])
            );
        end
    endgenerate

    // Slot counter advances past the channel just served; resync flags a
    // start of frame that arrived while the counter was out of phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_r   <= {SEL_W{1'b0}};
            resync_r <= 1'b0;
        end else if (ROUND_ROBIN && acc_s) begin
            slot_r   <= next_slot(dest_s);
            resync_r <= in_sof && (slot_r != {SEL_W{1'b0}});
        end else begin
            slot_r   <= slot_r;
            resync_r <= 1'b0;
        end
    end

    assign out_valid = full_s;
    assign slot      = slot_r;
    assign resync    = resync_r;

endmodule

// File: doc/demux4_router.md
# demux4_router

Registered 1-to-4 demultiplexer/router: the distributing counterpart of the 4:1 select multiplexer in our gate-level test circuits. It accepts words from a single valid/ready source and delivers each one to one of four output channels, chosen by an explicit select or by an internal round-robin slot counter (TDM mode). Each channel has a one-entry holding buffer, so a stalled channel back-pressures only the words addressed to it. The block sits between a shared producer and four independent consumers in the simulator's sequential test set.

## Interface
- `W`, 8: data width, in bits.
- `ROUND_ROBIN`, 0: 0 = the destination comes from `in_sel`; 1 = TDM mode, where the destination comes from the internal slot counter and `in_sel` is ignored.
- `clk` input 1: the single clock; every register updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input 1: the source has a word.
- `in_ready` output 1: the block accepts the word this cycle.
- `in_data` input W: input word.
- `in_sel` input 2: destination channel (only used when ROUND_ROBIN=0).
- `in_sof` input 1: start of frame (TDM mode only); only qualified by `in_valid`.
- `out_valid` output 4: bit k = channel k holds a word.
- `out_ready` input 4: bit k = consumer k takes the word.
- `out_data` output 4*W: channel k's word is at `[k*W +: W]`.
- `slot` output 2: current round-robin slot (always 0 when ROUND_ROBIN=0).
- `resync` output 1: one-cycle registered pulse, TDM framing correction.

## Operation
- Accept: `acc = in_valid && in_ready`.
- Destination `dest`:
  - ROUND_ROBIN=0: `dest = in_sel`.
  - ROUND_ROBIN=1: `dest = in_sof ? 0 : slot`.
- `in_ready = !full[dest] || out_ready[dest]`. This is combinational from `out_ready`, `in_sel`, `in_sof` and `slot`. `in_ready` may be high while `in_valid` is low.
- Channel k buffer, registers `full_k` and `data_k`:
  - Drain: `out_valid[k] && out_ready[k]`.
  - Load: `acc && dest==k`.
  - Load only: full_k←1, data_k←in_data.
  - Drain only: full_k←0, data_k holds its value.
  - Load and drain in the same cycle: full_k stays 1 and data_k←in_data. No bubble, no loss.
  - Channels are fully independent; a stall on one never blocks a word addressed to another.
- `out_valid[k] = full_k`. `out_data` slice k = data_k, which is registered and holds its value while `out_valid` is low.
- Slot counter (TDM mode only):
  - On `acc`: `slot ← dest + 1`, modulo 4. 3 wraps to 0.
  - With no `acc`, `slot` holds. `in_sof` without `in_valid` has no effect.
- `resync` (TDM mode only): asserted the cycle after an `acc` with `in_sof=1` and `slot≠0`. The word goes to channel 0 and `slot` becomes 1.
- Ordering: each channel delivers words in acceptance order. Nothing is dropped or duplicated.

## Timing
- Reset state: all `full_k`=0, all `data_k`=0, `slot`=0, `resync`=0. As a result `out_valid`=0, `out_data`=0 and `in_ready`=1.
- `rst` overrides a load or drain in the same cycle. Words held when `rst` asserts are discarded.
- Latency: a word accepted at edge n is on `out_valid`/`out_data` from edge n to edge n+1. That is one cycle.
- Throughput:
  - One word per cycle while the destination consumer holds `out_ready`=1.
  - Also one word per cycle while successive words target channels that are not full.
- The `resync` pulse lasts exactly one cycle. It comes one cycle after the triggering accept.

## Structure
- Shared package `demux4_pkg`:
  - `NCH=4`, `SEL_W=2`.
  - `typedef logic [SEL_W-1:0] chan_t`.
- Sub-module `demux_chan_buf`: a one-entry valid/ready holding register, parameterised by W, exposing `load`, `drain`, `full` and `data`. It is instantiated four times.
- Top level holds: destination selection, the `in_ready` mux, the slot counter and `resync`.

## Test plan
- Addressed routing (ROUND_ROBIN=0, all `out_ready`=1):
  - Stimulus: send 0x11, 0x22, 0x33, 0x44 with `in_sel` 0, 1, 2, 3 on consecutive cycles.
  - Response: each word appears on its channel exactly one cycle later; `in_ready` stays 1 throughout.
- Back-pressure isolation:
  - Stimulus: `out_ready[2]`=0; send 0xA0 then 0xA1 to channel 2, then 0xB0 to channel 1.
  - Response: 0xA0 is held; `in_ready`=0 while 0xA1 is presented; raising `out_ready[2]` lets 0xA1 through the same cycle with no bubble; 0xB0 is then delivered the cycle after it is accepted.
- Simultaneous load/drain:
  - Stimulus: channel 0 full with 0x55 and `out_ready[0]`=1; send 0x66 to channel 0.
  - Response: `out_valid[0]` stays 1, `out_data` moves 0x55→0x66, and each word is seen exactly once.
- TDM order and wrap (ROUND_ROBIN=1):
  - Stimulus: send 0x01..0x06 with `in_sof` on the first word.
  - Response: words go to channels 0, 1, 2, 3, 0, 1; `slot` reads 2 at the end; `resync` stays 0.
- TDM resync:
  - Stimulus: at `slot`=2, send 0x77 with `in_sof`=1.
  - Response: 0x77 lands on channel 0, `slot`=1 and `resync` pulses high for one cycle.
- Reset mid-operation:
  - Stimulus: with channels 1 and 3 full and `slot`=3, assert `rst` for one cycle.
  - Response: `out_valid`=0, `out_data`=0, `slot`=0 and `in_ready`=1 on the next cycle.
